// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// WIDTH bits are resolved GROUP bits per stage; the carry between slices
// is registered, so a beat spends one cycle per slice (NSTAGE cycles total).
// The pipeline advances as a whole and stalls as a whole under backpressure.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSTAGE = WIDTH / GROUP;

    if (WIDTH % GROUP != 0) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    // One lookahead slice. Returns {carry into slice MSB, slice carry-out, slice sum}.
    // Every in-slice carry is a flat sum of products over g/p and cin, and the
    // carry-out comes from the group generate/propagate pair.
    function automatic logic [GROUP+1:0] cla_slice(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] c;
        logic             grp_g;
        logic             grp_p;
        logic             cout;
        logic             term;
        logic             acc_c;
        logic             acc_g;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        grp_g = 1'b0;
        for (int j = 0; j <= GROUP; j++) begin
            acc_c = cin;
            for (int i = 0; i < j; i++) begin
                acc_c = acc_c & p[i];
            end
            acc_g = 1'b0;
            for (int m = 0; m < j; m++) begin
                term = g[m];
                for (int i = m + 1; i < j; i++) begin
                    term = term & p[i];
                end
                acc_g = acc_g | term;
            end
            if (j < GROUP) begin
                c[j] = acc_g | acc_c;
            end else begin
                grp_g = acc_g;
            end
        end
        grp_p = &p;
        cout  = grp_g | (grp_p & cin);
        return {c[GROUP-1], cout, p ^ c};
    endfunction

    logic [WIDTH-1:0] a_q [NSTAGE];
    logic [WIDTH-1:0] a_d [NSTAGE];
    logic [WIDTH-1:0] b_q [NSTAGE];
    logic [WIDTH-1:0] b_d [NSTAGE];
    logic [WIDTH-1:0] s_q [NSTAGE];
    logic [WIDTH-1:0] s_d [NSTAGE];
    logic [NSTAGE-1:0] c_q;
    logic [NSTAGE-1:0] c_d;
    logic [NSTAGE-1:0] v_q;
    logic [NSTAGE-1:0] v_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [WIDTH-1:0]  feed_a [NSTAGE];
    logic [WIDTH-1:0]  feed_b [NSTAGE];
    logic [WIDTH-1:0]  feed_s [NSTAGE];
    logic [NSTAGE-1:0] feed_c;
    logic [NSTAGE-1:0] feed_v;
    logic [GROUP+1:0]  slc [NSTAGE];
    logic              adv;

    assign adv       = ~v_q[NSTAGE-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTAGE-1];
    assign out_sum   = s_q[NSTAGE-1];
    assign out_cout  = c_q[NSTAGE-1];
    assign out_ovf   = ovf_q;

    // Stage inputs: stage 0 takes the conditioned operands (zeroed for a bubble),
    // later stages take the previous stage registers; then each stage resolves its slice.
    always_comb begin
        feed_c = '0;
        feed_v = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            feed_a[k] = '0;
            feed_b[k] = '0;
            feed_s[k] = '0;
        end
        feed_v[0] = in_valid;
        if (in_valid) begin
            feed_a[0] = in_a;
            feed_b[0] = in_sub ? ~in_b : in_b;
            feed_c[0] = in_sub ? ~in_cin : in_cin;
        end
        for (int k = 1; k < NSTAGE; k++) begin
            feed_a[k] = a_q[k-1];
            feed_b[k] = b_q[k-1];
            feed_s[k] = s_q[k-1];
            feed_c[k] = c_q[k-1];
            feed_v[k] = v_q[k-1];
        end
        for (int k = 0; k < NSTAGE; k++) begin
            slc[k] = cla_slice(feed_a[k][k*GROUP +: GROUP], feed_b[k][k*GROUP +: GROUP], feed_c[k]);
        end
    end

    // Next state: every stage shifts together on adv, otherwise everything holds.
    always_comb begin
        c_d   = c_q;
        v_d   = v_q;
        ovf_d = ovf_q;
        for (int k = 0; k < NSTAGE; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
        end
        if (adv) begin
            for (int k = 0; k < NSTAGE; k++) begin
                a_d[k] = feed_a[k];
                b_d[k] = feed_b[k];
                s_d[k] = feed_s[k];
                s_d[k][k*GROUP +: GROUP] = slc[k][GROUP-1:0];
                c_d[k] = slc[k][GROUP];
                v_d[k] = feed_v[k];
            end
            ovf_d = slc[NSTAGE-1][GROUP+1] ^ slc[NSTAGE-1][GROUP];
        end
    end

    // Pipeline registers; reset discards every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NS = W / G;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W+1:0] val;
        int           cyc;
    } sb_t;

    sb_t          sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic         acc;
    logic         cons;
    int           cons_cyc;
    logic [W+1:0] got;
    logic [W+1:0] drv_exp;

    // Reference: {cout, ovf, sum} from a WIDTH+1 bit add.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic         ovf;
        bb   = sub ? ~b : b;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, full[W-1:0]};
    endfunction

    task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        in_a    = a;
        in_b    = b;
        in_cin  = cin;
        in_sub  = sub;
        drv_exp = model(a, b, cin, sub);
    endtask

    // Advance one clock: note handshakes just before the edge, push accepted beats.
    task automatic tick();
        acc      = in_valid && in_ready;
        cons     = out_valid && out_ready;
        got      = {out_cout, out_ovf, out_sum};
        cons_cyc = cyc;
        if (acc) sb.push_back('{val: drv_exp, cyc: cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_beat('0, '0, 1'b0, 1'b0);
        tick(); tick();
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b sum=%h c=%b o=%b want all zero", out_valid, out_sum, out_cout, out_ovf);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic [1:0]   tcs [5];
        logic [W+1:0] te [5];
        sb_t          e;
        ta[0] = 16'hFFFF; tb[0] = 16'h0001; tcs[0] = 2'b00; te[0] = {1'b1, 1'b0, 16'h0000};
        ta[1] = 16'h7FFF; tb[1] = 16'h0001; tcs[1] = 2'b00; te[1] = {1'b0, 1'b1, 16'h8000};
        ta[2] = 16'h8000; tb[2] = 16'h0001; tcs[2] = 2'b01; te[2] = {1'b1, 1'b1, 16'h7FFF};
        ta[3] = 16'h0003; tb[3] = 16'h0005; tcs[3] = 2'b01; te[3] = {1'b0, 1'b0, 16'hFFFE};
        ta[4] = 16'h0003; tb[4] = 16'h0005; tcs[4] = 2'b11; te[4] = {1'b0, 1'b0, 16'hFFFD};
        out_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (n < 5) begin
                set_beat(ta[n], tb[n], tcs[n][1], tcs[n][0]);
                drv_exp  = te[n];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (cons) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL directed_unexpected got=%h want no output", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.val) begin
                        failures++;
                        $display("FAIL directed_result got={cout,ovf,sum}=%h want %h", got, e.val);
                    end
                    checks++;
                    if (cons_cyc - e.cyc != NS) begin
                        failures++;
                        $display("FAIL directed_latency got=%0d want %0d", cons_cyc - e.cyc, NS);
                    end
                end
            end
            if (n >= 5 && sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL directed_drain got pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        int  first_cyc = -1;
        int  ncons = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n < 8) begin
                set_beat(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (n < 8) begin
                checks++;
                if (!acc) begin
                    failures++;
                    $display("FAIL b2b_accept got in_ready=0 want 1 at beat %0d", n);
                end
            end
            if (cons) begin
                if (first_cyc < 0) first_cyc = cons_cyc;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected got=%h want no output", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e.val || cons_cyc != first_cyc + ncons || cons_cyc - e.cyc != NS) begin
                        failures++;
                        $display("FAIL b2b_result got=%h at cyc %0d want %h at cyc %0d (lat %0d)",
                                 got, cons_cyc, e.val, first_cyc + ncons, NS);
                    end
                end
                ncons++;
            end
            if (n >= 8 && sb.size() == 0) break;
        end
        checks++;
        if (ncons != 8 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d want 8", ncons);
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        sb_t          e;
        logic [W+1:0] held;
        logic [W-1:0] pa [6];
        logic [W-1:0] pb [6];
        int           idx = 0;
        int           last = -1;
        int           ncons = 0;
        for (int i = 0; i < 6; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        out_ready = 1'b0;
        for (int n = 0; n < 12 && !out_valid; n++) begin
            set_beat(pa[idx], pb[idx], 1'(idx), 1'(idx >> 1));
            in_valid = 1'b1;
            tick();
            if (acc) idx++;
        end
        checks++;
        if (idx != NS || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_fill got accepted=%0d out_valid=%b want %0d 1", idx, out_valid, NS);
        end
        held = {out_cout, out_ovf, out_sum};
        for (int n = 0; n < 5; n++) begin
            set_beat(pa[idx], pb[idx], 1'(idx), 1'(idx >> 1));
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready got=%b want 0", in_ready);
            end
            tick();
            checks++;
            if ({out_cout, out_ovf, out_sum} !== held || out_valid !== 1'b1 || acc || cons) begin
                failures++;
                $display("FAIL bp_hold got=%h v=%b want %h v=1", {out_cout, out_ovf, out_sum}, out_valid, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            tick();
            if (cons) begin
                checks++;
                e = sb.pop_front();
                if (got !== e.val || (last >= 0 && cons_cyc != last + 1)) begin
                    failures++;
                    $display("FAIL bp_drain got=%h at cyc %0d want %h at cyc %0d", got, cons_cyc, e.val, last + 1);
                end
                last = cons_cyc;
                ncons++;
            end
        end
        checks++;
        if (ncons != NS || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_count got=%0d want %0d", ncons, NS);
            sb.delete();
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        set_beat(16'h1234, 16'h1111, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        set_beat(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        tick();
        set_beat(16'h5555, 16'h2222, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h2345) begin
            failures++;
            $display("FAIL mid_pre got v=%b sum=%h want 1 2345", out_valid, out_sum);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf} !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got v=%b sum=%h c=%b o=%b rdy=%b want 0 0 0 0 1",
                     out_valid, out_sum, out_cout, out_ovf, in_ready);
        end
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale got out_valid=%b sum=%h want 0", out_valid, out_sum);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready got=%b want 1", in_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
